ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- System-clocked successor to the PS2_CLK-domain digit decoder.
- Oversamples PS2_CLK/PS2_DAT on CLOCK_50 and checks the full 11-bit frame (start, odd parity, stop, timeout).
- Decodes E0 (extended) and F0 (break) prefixes and keeps a parametrised held-key bitmap.
- Queues every key event in a small FIFO with a valid/ready interface for the game/solver logic.

Parameters:
- NUM_KEYS, 16: held-key bitmap width; uses the first NUM_KEYS entries of the package key table (1..16).
- FIFO_DEPTH, 8: event FIFO entries; power of two, 2..64.
- TIMEOUT_CYCLES, 100000: CLOCK_50 cycles with no PS2_CLK falling edge before a partial frame is aborted (2 ms at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- PS2_CLK  in  1  raw PS/2 clock, asynchronous.
- PS2_DAT  in  1  raw PS/2 data, asynchronous.
- key_down  out  NUM_KEYS  1 = key i currently held.
- ev_valid  out  1  FIFO not empty.
- ev_ready  in  1  consumer pops the head when ev_valid & ev_ready.
- ev_code  out  8  head event scan code.
- ev_ext  out  1  head event had E0 prefix.
- ev_break  out  1  head event is a release.
- frame_err  out  1  one-cycle pulse on a bad start, parity or stop bit, or on timeout.
- overflow  out  1  sticky; an event was dropped on a full FIFO; cleared only by RESET.

Behaviour:
- Reset (sync, CLOCK_50): all outputs 0; FIFO empty; both FSMs idle; prefix flags clear; synchronisers reset to 1.
- Input conditioning:
  - 2-FF synchroniser on each PS/2 line.
  - Falling edge = previous synced clock 1, current 0. All sampling happens on that edge cycle, using synced data.
- Frame FSM, one transition per falling edge:
  - IDLE: data 0 -> DATA (bit count 0); data 1 -> frame_err, stay IDLE.
  - DATA: shift LSB first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: stop = 1 and (data XOR parity) has odd weight -> byte valid. Otherwise frame_err. Always -> IDLE.
- Timeout:
  - Counter clears on every falling edge and counts while not IDLE.
  - On reaching TIMEOUT_CYCLES: -> IDLE, frame_err pulse, partial byte discarded.
- Classification, cycle after a valid STOP edge (call the STOP edge cycle S):
  - E0 sets ext; F0 sets brk. Either order is accepted.
  - Any other byte is an event {ext, brk, code}; both flags clear in the same cycle.
  - Erroneous frames leave the flags unchanged.
- key_down:
  - Updated at the end of S+1 for non-extended codes matching table entry i < NUM_KEYS.
  - Make sets bit i; break clears it.
  - Extended codes never touch key_down.
- FIFO:
  - Written at the end of S+1; ev_valid is high from S+2 (latency 2 cycles).
  - Outputs come from the registered head.
  - Full and no pop: event dropped, overflow set.
  - Full with a same-cycle pop: push accepted, count unchanged.
  - Empty: ev_ready ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame or mid-prefix: everything is discarded; the first complete frame afterwards is decoded normally.

Optional Feature:
- TYPEMATIC_FILTER_EN defined: a make event for a table key already held in key_down is not pushed (auto-repeat suppressed); key_down is unaffected.
- Not defined: every make event is pushed, including repeats.
- Extended and non-table codes are always pushed.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_EXT = 8'hE0 and PS2_BRK = 8'hF0;
  - the 16-entry key table, in this order: 45 16 1E 26 25 2E 36 3D 3E 46 (digits 0-9), 5A Enter, 66 Backspace, 79 keypad +, 7B keypad -, 7C keypad *, 4A /;
  - the event struct {ext, brk, code}.
- Sub-module ps2_frame_rx: synchronisers, edge detect, frame FSM and timeout. Outputs a byte-valid pulse, the byte, and frame_err.
- Classification, key_down and the FIFO stay in the top module.

Test Plan:
- Frame 0x16 with parity 0, then F0, 16 -> key_down[1] high at S+1 then low. FIFO events {0,0,16} then {0,1,16}; ev_ready = 1 pops both.
- E0 75, E0 F0 75 -> events {1,0,75} and {1,1,75}; key_down stays 0.
- Frame 0x45 with a wrong parity bit -> frame_err pulse, no event, key_down[0] = 0. Next good 0x45 -> key_down[0] = 1.
- Send 6 bits, then idle 100000 cycles -> frame_err exactly once. Following full frame 0x1E decodes; key_down[2] = 1.
- ev_ready = 0, push 9 events with FIFO_DEPTH = 8 -> 8 retained, overflow = 1. Pop all -> first 8 codes in order.
- 0x26 make sent 3 times -> 3 events without TYPEMATIC_FILTER_EN, 1 event with it; key_down[3] = 1 in both builds.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard decoder:
//   - PS2_EXT / PS2_BRK : extended and break prefix bytes
//   - key_code()        : 16-entry scan-code table (digits 0-9, Enter,
//                         Backspace, keypad +, keypad -, keypad *, /)
//   - ps2_event_t       : queued key event {ext, brk, code}
//   - rx_state_t        : frame receiver states
// ---------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam int         KEY_TABLE_SIZE = 16;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Table index i corresponds to bit i of the held-key bitmap.
    function automatic logic [7:0] key_code(input int idx);
        case (idx)
            0:       key_code = 8'h45;
            1:       key_code = 8'h16;
            2:       key_code = 8'h1E;
            3:       key_code = 8'h26;
            4:       key_code = 8'h25;
            5:       key_code = 8'h2E;
            6:       key_code = 8'h36;
            7:       key_code = 8'h3D;
            8:       key_code = 8'h3E;
            9:       key_code = 8'h46;
            10:      key_code = 8'h5A;
            11:      key_code = 8'h66;
            12:      key_code = 8'h79;
            13:      key_code = 8'h7B;
            14:      key_code = 8'h7C;
            15:      key_code = 8'h4A;
            default: key_code = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
// Oversamples the raw PS/2 lines on the system clock and receives 11-bit
// frames (start, 8 data LSB first, odd parity, stop).
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ps2_clk/ps2_dat raw asynchronous PS/2 lines
//   byte_valid      one-cycle pulse, byte_data holds a good byte
//   byte_data       last received byte (stable while byte_valid)
//   frame_err       one-cycle pulse on bad start/parity/stop or timeout
// ---------------------------------------------------------------------------
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic            clk_s1_q, clk_s2_q, clk_s3_q;
    logic            dat_s1_q, dat_s2_q;
    rx_state_t       state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            fall;

    // clk_s3_q is the previous synchronised clock, so a 1->0 step between
    // s3 and s2 marks the one cycle on which the data line is sampled.
    assign fall = clk_s3_q & ~clk_s2_q;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tmo_cnt_d    = tmo_cnt_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (fall) begin
            tmo_cnt_d = '0;
            case (state_q)
                RX_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                RX_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    parity_d = dat_s2_q;
                    state_d  = RX_STOP;
                end
                default: begin
                    // Odd parity: data plus parity bit must have odd weight.
                    if (dat_s2_q && (^{shift_q, parity_q})) byte_valid_d = 1'b1;
                    else                                   frame_err_d  = 1'b1;
                    state_d = RX_IDLE;
                end
            endcase
        end else if (state_q != RX_IDLE) begin
            // A stalled partial frame is abandoned so the next start bit
            // is not misread as a data bit.
            if (tmo_cnt_q == TMO_LAST) begin
                state_d     = RX_IDLE;
                tmo_cnt_d   = '0;
                frame_err_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
        end else begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            clk_s3_q     <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            state_q      <= RX_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            tmo_cnt_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_s1_q     <= ps2_clk;
            clk_s2_q     <= clk_s1_q;
            clk_s3_q     <= clk_s2_q;
            dat_s1_q     <= ps2_dat;
            dat_s2_q     <= dat_s1_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_cnt_q    <= tmo_cnt_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// PS/2 keyboard front end on CLOCK_50: receives frames, decodes E0/F0
// prefixes, tracks held table keys and queues key events in a FIFO.
// Ports:
//   CLOCK_50, RESET          system clock, synchronous active-high reset
//   PS2_CLK, PS2_DAT         raw asynchronous PS/2 lines
//   key_down[NUM_KEYS]       bit i = table key i currently held
//   ev_valid/ev_ready        FIFO head handshake
//   ev_code/ev_ext/ev_break  head event
//   frame_err                one-cycle pulse on a bad or timed-out frame
//   overflow                 sticky, an event was dropped on a full FIFO
// Build option: define TYPEMATIC_FILTER_EN to suppress auto-repeat make
// events for table keys that are already held.
// ---------------------------------------------------------------------------
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int NUM_KEYS       = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                PS2_CLK,
    input  logic                PS2_DAT,
    output logic [NUM_KEYS-1:0] key_down,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [7:0]          ev_code,
    output logic                ev_ext,
    output logic                ev_break,
    output logic                frame_err,
    output logic                overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic                rx_valid;
    logic [7:0]          rx_byte;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic [NUM_KEYS-1:0] key_down_q, key_down_d;
    ps2_event_t          mem_q [FIFO_DEPTH];
    ps2_event_t          mem_d [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                push_req, push, pop, full;
    ps2_event_t          new_ev, head;
`ifdef TYPEMATIC_FILTER_EN
    logic                held_repeat;
`endif

    ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk        (CLOCK_50),
        .rst        (RESET),
        .ps2_clk    (PS2_CLK),
        .ps2_dat    (PS2_DAT),
        .byte_valid (rx_valid),
        .byte_data  (rx_byte),
        .frame_err  (frame_err)
    );

    // Prefix tracking and held-key bitmap. Prefixes accumulate until a
    // non-prefix byte arrives, which becomes the event and clears them.
    always_comb begin
        ext_d      = ext_q;
        brk_d      = brk_q;
        key_down_d = key_down_q;
        push_req   = 1'b0;
        new_ev     = '{ext: ext_q, brk: brk_q, code: rx_byte};
`ifdef TYPEMATIC_FILTER_EN
        held_repeat = 1'b0;
`endif
        if (rx_valid) begin
            if (rx_byte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_d = 1'b1;
            end else begin
                push_req = 1'b1;
                ext_d    = 1'b0;
                brk_d    = 1'b0;
                if (!ext_q) begin
                    for (int i = 0; i < NUM_KEYS; i++) begin
                        if (rx_byte == key_code(i)) begin
`ifdef TYPEMATIC_FILTER_EN
                            if (!brk_q && key_down_q[i]) held_repeat = 1'b1;
`endif
                            key_down_d[i] = ~brk_q;
                        end
                    end
                end
            end
        end
`ifdef TYPEMATIC_FILTER_EN
        push_req = push_req & ~held_repeat;
`endif
    end

    // Event FIFO. A push into a full FIFO is still accepted when the head
    // is popped in the same cycle; otherwise the event is lost.
    always_comb begin
        pop        = (count_q != '0) & ev_ready;
        full       = (count_q == CW'(FIFO_DEPTH));
        push       = push_req & (~full | pop);
        overflow_d = overflow_q | (push_req & full & ~pop);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_ev;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            key_down_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            key_down_q <= key_down_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign key_down = key_down_q;
    assign ev_valid = (count_q != '0);
    assign ev_code  = head.code;
    assign ev_ext   = head.ext;
    assign ev_break = head.brk;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames bit by bit and
// checks the held-key bitmap, event FIFO, error pulses and overflow.
module tb_ps2_key_decoder;

    logic        CLOCK_50 = 1'b0;
    logic        RESET;
    logic        PS2_CLK;
    logic        PS2_DAT;
    logic [15:0] key_down;
    logic        ev_valid;
    logic        ev_ready;
    logic [7:0]  ev_code;
    logic        ev_ext;
    logic        ev_break;
    logic        frame_err;
    logic        overflow;

    int checks    = 0;
    int failures  = 0;
    int errPulses = 0;

    ps2_key_decoder #(
        .NUM_KEYS       (16),
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .key_down  (key_down),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_break  (ev_break),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // frame_err is a one-cycle pulse, so sampling once per cycle counts each
    always @(negedge CLOCK_50) if (frame_err) errPulses++;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic sendBit(input logic b);
        PS2_DAT = b;
        repeat (5) @(negedge CLOCK_50);
        PS2_CLK = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        PS2_CLK = 1'b1;
        repeat (5) @(negedge CLOCK_50);
    endtask

    task automatic applyStimulus(input logic [7:0] code, input logic badParity);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(code[i]);
        sendBit((~^code) ^ badParity);
        sendBit(1'b1);
        PS2_DAT = 1'b1;
        repeat (10) @(negedge CLOCK_50);
    endtask

    task automatic popEvent(input string tag, input logic ext, input logic brk,
                            input logic [7:0] code);
        checkOutput({tag, " valid"}, 32'(ev_valid), 32'd1);
        checkOutput({tag, " event"}, 32'({ev_ext, ev_break, ev_code}), 32'({ext, brk, code}));
        ev_ready = 1'b1;
        @(negedge CLOCK_50);
        ev_ready = 1'b0;
    endtask

    logic [7:0] ovCodes [9] = '{8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                8'h46, 8'h5A, 8'h66, 8'h79};

    initial begin
        int errBefore;
        int nEvents;
        int expEvents;
        PS2_CLK  = 1'b1;
        PS2_DAT  = 1'b1;
        ev_ready = 1'b0;
        doReset();

        checkOutput("reset key_down", 32'(key_down), 32'h0);
        checkOutput("reset ev_valid", 32'(ev_valid), 32'h0);
        checkOutput("reset ev_code", 32'({ev_ext, ev_break, ev_code}), 32'h0);
        checkOutput("reset frame_err", 32'(frame_err), 32'h0);
        checkOutput("reset overflow", 32'(overflow), 32'h0);

        // Make then break of digit 1
        applyStimulus(8'h16, 1'b0);
        checkOutput("make 16 key_down", 32'(key_down), 32'h0002);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h16, 1'b0);
        checkOutput("break 16 key_down", 32'(key_down), 32'h0000);
        popEvent("ev make16", 1'b0, 1'b0, 8'h16);
        popEvent("ev brk16", 1'b0, 1'b1, 8'h16);
        checkOutput("drained ev_valid", 32'(ev_valid), 32'h0);

        // Extended make and break, prefixes in E0 F0 order
        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'h75, 1'b0);
        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h75, 1'b0);
        checkOutput("ext key_down", 32'(key_down), 32'h0000);
        popEvent("ev ext make", 1'b1, 1'b0, 8'h75);
        popEvent("ev ext brk", 1'b1, 1'b1, 8'h75);

        // Popping an empty FIFO must be ignored
        ev_ready = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        ev_ready = 1'b0;
        checkOutput("empty pop ev_valid", 32'(ev_valid), 32'h0);

        // Bad parity, then a good frame of the same key
        errBefore = errPulses;
        applyStimulus(8'h45, 1'b1);
        checkOutput("parity err pulses", 32'(errPulses - errBefore), 32'd1);
        checkOutput("parity err ev_valid", 32'(ev_valid), 32'h0);
        checkOutput("parity err key_down", 32'(key_down), 32'h0000);
        applyStimulus(8'h45, 1'b0);
        checkOutput("good 45 key_down", 32'(key_down), 32'h0001);
        popEvent("ev 45", 1'b0, 1'b0, 8'h45);

        // Partial frame of 6 bits followed by silence
        errBefore = errPulses;
        sendBit(1'b0);
        for (int i = 0; i < 5; i++) sendBit(1'b1);
        repeat (300) @(negedge CLOCK_50);
        checkOutput("timeout err pulses", 32'(errPulses - errBefore), 32'd1);
        checkOutput("timeout ev_valid", 32'(ev_valid), 32'h0);
        applyStimulus(8'h1E, 1'b0);
        checkOutput("after timeout key_down", 32'(key_down), 32'h0005);
        popEvent("ev 1E", 1'b0, 1'b0, 8'h1E);

        // Nine events into an eight-entry FIFO
        for (int i = 0; i < 9; i++) applyStimulus(ovCodes[i], 1'b0);
        checkOutput("overflow flag", 32'(overflow), 32'h1);
        checkOutput("overflow key_down", 32'(key_down), 32'h1FF5);
        for (int i = 0; i < 8; i++) popEvent($sformatf("ov pop %0d", i), 1'b0, 1'b0, ovCodes[i]);
        checkOutput("ov drained ev_valid", 32'(ev_valid), 32'h0);
        checkOutput("overflow sticky", 32'(overflow), 32'h1);

        // Auto-repeat of digit 3
        for (int i = 0; i < 3; i++) applyStimulus(8'h26, 1'b0);
`ifdef TYPEMATIC_FILTER_EN
        expEvents = 1;
`else
        expEvents = 3;
`endif
        nEvents = 0;
        while (ev_valid && nEvents < 5) begin
            popEvent("ev repeat", 1'b0, 1'b0, 8'h26);
            nEvents++;
        end
        checkOutput("repeat event count", 32'(nEvents), 32'(expEvents));
        checkOutput("repeat key_down", 32'(key_down), 32'h1FFD);

        // Reset after an extended prefix and in the middle of a frame
        applyStimulus(8'hE0, 1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        doReset();
        checkOutput("midreset overflow", 32'(overflow), 32'h0);
        checkOutput("midreset key_down", 32'(key_down), 32'h0000);
        checkOutput("midreset ev_valid", 32'(ev_valid), 32'h0);
        applyStimulus(8'h16, 1'b0);
        checkOutput("post reset key_down", 32'(key_down), 32'h0002);
        popEvent("ev post reset", 1'b0, 1'b0, 8'h16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
